// File: rtl/regfile_pkg.sv
// Shared constants and types for the 2-read/1-write register file.
package regfile_pkg;

   localparam int ADDR_W = 5;
   localparam int NREGS  = 32;
   localparam int WIDTH  = 64;

   localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

   typedef logic [WIDTH-1:0]  word_t;
   typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/reg_file_2r1w_reg_word.sv
// One enabled storage word of the register file, cleared by synchronous reset.
module reg_word #(
   parameter int WIDTH = regfile_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_q;

   // NOTE: every word is reset (not left as bare storage) so reads after reset are defined; non-blocking keeps all words updating on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= '0;
      end else if (en) begin
         r_q <= d;
      end
   end

   assign q = r_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// 32-entry register file, two combinational read ports, one write port, X31 reads zero.
module reg_file_2r1w
   import regfile_pkg::ZERO_REG, regfile_pkg::addr_t;
#(
   parameter int WIDTH  = regfile_pkg::WIDTH,
   parameter int NREGS  = regfile_pkg::NREGS,
   parameter int BYPASS = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             reg_write,
   input  addr_t            write_reg,
   input  logic [WIDTH-1:0] write_data,
   input  addr_t            read_reg1,
   input  addr_t            read_reg2,
   output logic [WIDTH-1:0] read_data1,
   output logic [WIDTH-1:0] read_data2
);

   // Only words 0..NREGS-2 exist; the zero register has no enable and no storage.
   logic [NREGS-2:0] w_word_en;
   logic [WIDTH-1:0] w_word_q [NREGS-1];
   logic [WIDTH-1:0] w_rd1;
   logic [WIDTH-1:0] w_rd2;
   logic             w_fwd1;
   logic             w_fwd2;

   // NOTE: each combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_word_en = '0;
      for (int k = 0; k < NREGS - 1; k++) begin
         w_word_en[k] = reg_write && (write_reg == addr_t'(k));
      end
   end

   for (genvar g = 0; g < NREGS - 1; g++) begin : g_word
      reg_word #(
         .WIDTH (WIDTH)
      ) u_word (
         .clk   (clk),
         .reset (reset),
         .en    (w_word_en[g]),
         .d     (write_data),
         .q     (w_word_q[g])
      );
   end

   always_comb begin
      w_rd1 = '0;
      w_rd2 = '0;
      for (int k = 0; k < NREGS - 1; k++) begin
         if (read_reg1 == addr_t'(k)) w_rd1 = w_word_q[k];
         if (read_reg2 == addr_t'(k)) w_rd2 = w_word_q[k];
      end
   end

   // Forwarding is suppressed during reset so reads show the stored words.
   always_comb begin
      w_fwd1 = (BYPASS != 0) && reg_write && !reset &&
               (write_reg != ZERO_REG) && (read_reg1 == write_reg);
      w_fwd2 = (BYPASS != 0) && reg_write && !reset &&
               (write_reg != ZERO_REG) && (read_reg2 == write_reg);
   end

   assign read_data1 = w_fwd1 ? write_data : w_rd1;
   assign read_data2 = w_fwd2 ? write_data : w_rd2;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench: drives both BYPASS variants in lockstep and checks all four read ports.
module tb_reg_file_2r1w;

   localparam int W = 64;

   typedef struct {
      string        name;
      logic [W-1:0] b1_p1;
      logic [W-1:0] b1_p2;
      logic [W-1:0] b0_p1;
      logic [W-1:0] b0_p2;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         reg_write;
   logic [4:0]   write_reg;
   logic [W-1:0] write_data;
   logic [4:0]   read_reg1;
   logic [4:0]   read_reg2;
   logic [W-1:0] b1_rd1, b1_rd2, b0_rd1, b0_rd2;

   exp_t exp_q[$];
   int   n_total  = 0;
   int   n_passed = 0;
   bit   stim_done = 1'b0;

   always #5 clk = ~clk;

   reg_file_2r1w #(.WIDTH(W), .NREGS(32), .BYPASS(1)) u_byp (
      .clk        (clk),
      .reset      (reset),
      .reg_write  (reg_write),
      .write_reg  (write_reg),
      .write_data (write_data),
      .read_reg1  (read_reg1),
      .read_reg2  (read_reg2),
      .read_data1 (b1_rd1),
      .read_data2 (b1_rd2)
   );

   reg_file_2r1w #(.WIDTH(W), .NREGS(32), .BYPASS(0)) u_nobyp (
      .clk        (clk),
      .reset      (reset),
      .reg_write  (reg_write),
      .write_reg  (write_reg),
      .write_data (write_data),
      .read_reg1  (read_reg1),
      .read_reg2  (read_reg2),
      .read_data1 (b0_rd1),
      .read_data2 (b0_rd2)
   );

   function automatic logic [W-1:0] pat(input int i);
      logic [W-1:0] p;
      p = 64'h0101_0101;
      return (i == 31) ? '0 : p * W'(i);
   endfunction

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_total++;
      if (act === exp) n_passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Drive one cycle of inputs just after the edge; optionally queue the expected reads.
   task automatic cyc(input logic rst, input logic we, input logic [4:0] wa,
                      input logic [W-1:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                      input bit chk, input logic [W-1:0] e11, input logic [W-1:0] e12,
                      input logic [W-1:0] e01, input logic [W-1:0] e02, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      reset = rst; reg_write = we; write_reg = wa; write_data = wd;
      read_reg1 = r1; read_reg2 = r2;
      if (chk) begin
         e.name = nm; e.b1_p1 = e11; e.b1_p2 = e12; e.b0_p1 = e01; e.b0_p2 = e02;
         exp_q.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check({e.name, " byp.p1"},   b1_rd1, e.b1_p1);
         check({e.name, " byp.p2"},   b1_rd2, e.b1_p2);
         check({e.name, " nobyp.p1"}, b0_rd1, e.b0_p1);
         check({e.name, " nobyp.p2"}, b0_rd2, e.b0_p2);
      end
   end

   initial begin
      logic [W-1:0] v_dead, v_ones;
      v_dead = 64'hDEAD_BEEF_0000_0001;
      v_ones = '1;
      reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
      read_reg1 = 5'd31; read_reg2 = 5'd31;

      cyc(1, 0, 0, 0, 31, 31, 1, 0, 0, 0, 0, "x31_pre_reset");
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
      for (int i = 0; i < 32; i++)
         cyc(0, 0, 0, 0, 5'(i), 5'(31 - i), 1, 0, 0, 0, 0, "reset_sweep");

      cyc(0, 1, 5, v_dead, 5, 6, 1, v_dead, 0, 0, 0, "wr_x5_same_cycle");
      cyc(0, 0, 0, 0, 5, 6, 1, v_dead, 0, v_dead, 0, "rd_x5_x6");

      cyc(0, 1, 31, v_ones, 31, 31, 1, 0, 0, 0, 0, "wr_x31");
      for (int i = 0; i < 3; i++)
         cyc(0, 0, 0, 0, 31, 31, 1, 0, 0, 0, 0, "rd_x31_later");

      cyc(0, 1, 7, 64'h55, 0, 0, 1, 0, 0, 0, 0, "wr_x7_55");
      cyc(0, 1, 7, 64'h1234, 7, 7, 1, 64'h1234, 64'h1234, 64'h55, 64'h55, "bypass_x7");
      cyc(0, 0, 0, 0, 7, 7, 1, 64'h1234, 64'h1234, 64'h1234, 64'h1234, "after_x7");

      cyc(0, 1, 3, 64'hAA, 3, 7, 1, 64'hAA, 64'h1234, 0, 64'h1234, "wr_x3_aa");
      cyc(1, 1, 3, 64'hBB, 3, 3, 1, 64'hAA, 64'hAA, 64'hAA, 64'hAA, "reset_with_write");
      cyc(0, 0, 0, 0, 3, 7, 1, 0, 0, 0, 0, "after_reset_write");

      for (int i = 0; i < 31; i++)
         cyc(0, 1, 5'(i), pat(i), 5'(i), (i == 0) ? 5'd31 : 5'(i - 1), 1,
             pat(i), (i == 0) ? '0 : pat(i - 1), 0, (i == 0) ? '0 : pat(i - 1), "pattern_wr");

      for (int i = 0; i < 10; i++)
         cyc(0, 0, 5'(i * 3), (i % 2 == 0) ? v_ones : v_dead, 5'(i * 3), 5'(30 - i), 1,
             pat(i * 3), pat(30 - i), pat(i * 3), pat(30 - i), "hold_no_write");

      for (int i = 0; i < 32; i++)
         cyc(0, 0, 0, v_ones, 5'(i), 5'((i + 7) % 32), 1,
             pat(i), pat((i + 7) % 32), pat(i), pat((i + 7) % 32), "pattern_sweep");

      cyc(0, 0, 0, 0, 31, 31, 0, 0, 0, 0, 0, "");
      stim_done = 1'b1;
   end

   initial begin
      int budget;
      budget = 0;
      wait (stim_done);
      while (exp_q.size() > 0 && budget < 20) begin
         @(posedge clk);
         budget++;
      end
      if (exp_q.size() > 0) begin
         n_total++;
         $display("FAIL drain: %0d entries left, required 0", exp_q.size());
      end
      @(posedge clk);
      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
